// File: rtl/shift_scan_pkg.sv
// Shared types for the shift_scan_gen one-hot scanner: scan modes and FSM states.
package shift_scan_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'b00,
    MODE_ROT_R  = 2'b01,
    MODE_ROT_L  = 2'b10,
    MODE_SINGLE = 2'b11
  } scan_mode_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell counter for shift_scan_gen: strobes o_step on the enabled cycle where the count
// reaches i_dwell, so each position is held for i_dwell+1 enabled cycles.
module scan_dwell_timer #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RSTna,
  input  logic          i_clr,
  input  logic          i_ena,
  input  logic [DW-1:0] i_dwell,
  output logic          o_step
);

  logic [DW-1:0] r_cnt;

  assign o_step = i_ena && (r_cnt == i_dwell);

  always_ff @(posedge CLK or negedge RSTna) begin
    if (!RSTna) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_ena) begin
      r_cnt <= o_step ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shift_scan_gen.sv
// Parametrised one-hot scanner (bounce / rotate-right / rotate-left / single-shot) with dwell.
// Optional macro SCAN_TRAIL_EN: Q also lights the previous position (two-hot trail).
module shift_scan_gen
  import shift_scan_pkg::*;
#(
  parameter int N  = 8,
  parameter int DW = 8,
  localparam int W = $clog2(N)
) (
  input  logic          CLK,
  input  logic          RSTna,
  input  logic          ENA,
  input  logic          START,
  input  logic [1:0]    MODE,
  input  logic [W-1:0]  LO,
  input  logic [W-1:0]  HI,
  input  logic [DW-1:0] DWELL,
  output logic [N-1:0]  Q,
  output logic [W-1:0]  POS,
  output logic          DIR,
  output logic          TC_LO,
  output logic          TC_HI,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR,
  output scan_state_t   o_dbg_state
);

  localparam logic [W-1:0] LP_LAST = W'(N - 1);
  localparam logic [W:0]   LP_MAX  = (W + 1)'(N - 1);

  scan_state_t   r_state, r_state_nxt;
  scan_mode_t    r_mode;
  logic [W-1:0]  r_pos, r_lo, r_hi;
  logic [DW-1:0] r_dwell;
  logic          r_dir, r_tc_lo, r_tc_hi, r_done, r_err;

  logic          w_start_ok, w_tmr_ena, w_step;
  logic [W-1:0]  w_start_pos, w_pos_nxt;
  logic          w_dir_nxt, w_tc_lo, w_tc_hi, w_done;

  // START is a one-cycle request with no back-pressure: it is either accepted
  // (config latched, scan restarted) or rejected with a one-cycle ERR pulse.
  assign w_start_ok  = START && (LO <= HI) && ({1'b0, HI} <= LP_MAX);
  assign w_start_pos = (scan_mode_t'(MODE) == MODE_ROT_L) ? LO : HI;
  // Any START, even a rejected one, freezes the dwell counter that cycle.
  assign w_tmr_ena   = (r_state == ST_RUN) && ENA && !START;

  scan_dwell_timer #(.DW(DW)) u_dwell (
    .CLK     (CLK),
    .RSTna   (RSTna),
    .i_clr   (w_start_ok),
    .i_ena   (w_tmr_ena),
    .i_dwell (r_dwell),
    .o_step  (w_step)
  );

  always_ff @(posedge CLK or negedge RSTna) begin
    if (!RSTna) r_state <= ST_IDLE;
    else        r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start_ok) r_state_nxt = ST_RUN;
      ST_RUN: begin
        if (w_start_ok)          r_state_nxt = ST_RUN;
        else if (w_step && w_done) r_state_nxt = ST_IDLE;
      end
      default: r_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    BUSY        = (r_state == ST_RUN);
    o_dbg_state = r_state;
    POS         = r_pos;
    DIR         = r_dir;
    TC_LO       = r_tc_lo;
    TC_HI       = r_tc_hi;
    DONE        = r_done;
    ERR         = r_err;
  end

  // Next position for one step; LO==HI degenerates to a hold that hits both ends.
  always_comb begin
    w_pos_nxt = r_pos;
    w_dir_nxt = r_dir;
    w_tc_lo   = 1'b0;
    w_tc_hi   = 1'b0;
    w_done    = 1'b0;
    if (r_lo == r_hi) begin
      w_tc_lo = 1'b1;
      w_tc_hi = 1'b1;
      w_done  = (r_mode == MODE_SINGLE);
    end else begin
      case (r_mode)
        MODE_BOUNCE: begin
          if (r_dir) begin
            if (r_pos == r_lo) begin
              w_pos_nxt = r_lo + 1'b1;
              w_dir_nxt = 1'b0;
              w_tc_lo   = 1'b1;
            end else begin
              w_pos_nxt = r_pos - 1'b1;
            end
          end else begin
            if (r_pos == r_hi) begin
              w_pos_nxt = r_hi - 1'b1;
              w_dir_nxt = 1'b1;
              w_tc_hi   = 1'b1;
            end else begin
              w_pos_nxt = r_pos + 1'b1;
            end
          end
        end
        MODE_ROT_R: begin
          if (r_pos == r_lo) begin
            w_pos_nxt = r_hi;
            w_tc_lo   = 1'b1;
          end else begin
            w_pos_nxt = r_pos - 1'b1;
          end
        end
        MODE_ROT_L: begin
          if (r_pos == r_hi) begin
            w_pos_nxt = r_lo;
            w_tc_hi   = 1'b1;
          end else begin
            w_pos_nxt = r_pos + 1'b1;
          end
        end
        default: begin
          w_pos_nxt = r_pos - 1'b1;
          if (w_pos_nxt == r_lo) begin
            w_tc_lo = 1'b1;
            w_done  = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTna) begin
    if (!RSTna) begin
      r_pos   <= LP_LAST;
      r_dir   <= 1'b1;
      r_lo    <= '0;
      r_hi    <= LP_LAST;
      r_mode  <= MODE_BOUNCE;
      r_dwell <= '0;
      r_tc_lo <= 1'b0;
      r_tc_hi <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_tc_lo <= 1'b0;
      r_tc_hi <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= START && !w_start_ok;
      if (w_start_ok) begin
        r_lo    <= LO;
        r_hi    <= HI;
        r_mode  <= scan_mode_t'(MODE);
        r_dwell <= DWELL;
        r_pos   <= w_start_pos;
        r_dir   <= (scan_mode_t'(MODE) != MODE_ROT_L);
      end else if (w_step) begin
        r_pos   <= w_pos_nxt;
        r_dir   <= w_dir_nxt;
        r_tc_lo <= w_tc_lo;
        r_tc_hi <= w_tc_hi;
        r_done  <= w_done;
      end
    end
  end

`ifdef SCAN_TRAIL_EN
  logic [W-1:0] r_prev;

  always_ff @(posedge CLK or negedge RSTna) begin
    if (!RSTna)          r_prev <= LP_LAST;
    else if (w_start_ok) r_prev <= w_start_pos;
    else if (w_step)     r_prev <= r_pos;
  end

  assign Q = (N'(1) << r_pos) | (N'(1) << r_prev);
`else
  assign Q = N'(1) << r_pos;
`endif

endmodule
